pe_row_sched: RTL and testbench
===============================

// Module: pe_row_sched
// PURPOSE
//  Sequencer for a single 3-tap PE. Accepts an 8-bit pixel stream (DMA side),
//  keeps a sliding 3-pixel window per image row and drives the PE weights and
//  the {p, p_valid} interface. Collects the PE result {o, o_valid}, buffers it
//  and presents it as a 16-bit output stream with m_last on the last frame result.
//  Sits between the AXI-DMA stream adapters and one pe instance.
// PARAMETERS
//  IMG_W      32  pixels per row; must be >= 3; outputs per row = IMG_W-2
//  ROWS       32  rows per frame; must be >= 1
//  OUT_DEPTH  4   output FIFO entries; power of 2, >= 4
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  rstn         in   1   asynchronous, active-low reset
//  start        in   1   1-cycle pulse; begins a frame; ignored while busy
//  cfg_w        in   24  {w1,w2,w3}, signed 8-bit each; sampled when start is accepted
//  busy         out  1   high from the cycle after start until done
//  done         out  1   1-cycle pulse after the last output handshake
//  s_pix_data   in   8   unsigned pixel
//  s_pix_valid  in   1   pixel valid
//  s_pix_ready  out  1   pixel accepted when valid & ready
//  pe_w1/2/3    out  8   signed weights to PE, held stable for the whole frame
//  pe_p         out  24  {oldest,middle,newest} pixel window
//  pe_p_valid   out  1   window valid, registered
//  pe_o         in   16  signed PE result
//  pe_o_valid   in   1   PE result valid (1 cycle after pe_p_valid)
//  m_data       out  16  result stream data
//  m_valid      out  1   result valid
//  m_ready      in   1   result ready
//  m_last       out  1   high with the final result of the frame
// BEHAVIOUR
//  Reset (rstn=0, async): FSM=IDLE; busy, done, s_pix_ready, pe_p_valid, m_valid,
//   m_last = 0; pe_p, pe_w*, m_data = 0; FIFO empty; all counters = 0.
//  FSM: IDLE -start-> RUN; RUN -all ROWS*IMG_W pixels accepted-> DRAIN;
//   DRAIN -FIFO empty, nothing in flight-> DONE; DONE -> IDLE (done=1 for this one cycle).
//  Counters: col 0..IMG_W-1 wraps to 0 at row end and increments row; row 0..ROWS-1.
//  Window: each accepted pixel shifts in: win <= {win[15:0], pix}.
//   If col >= 2 at acceptance: next cycle pe_p = new window, pe_p_valid = 1, else 0.
//   The window never spans a row boundary (col restarts at 0).
//  In-flight credit: infl = pe_p_valid + pe_o_valid pending (0..2).
//   s_pix_ready = (state==RUN) & (fifo_cnt + infl + 1 <= OUT_DEPTH); results are never dropped.
//  FIFO push on pe_o_valid (data = pe_o unchanged); pop on m_valid & m_ready.
//   Simultaneous push and pop on full or empty FIFO is legal; count stays the same.
//   m_valid = !fifo_empty; m_data = FIFO head (first-word-fall-through).
//  m_last = 1 only when the head is result number ROWS*(IMG_W-2)-1 (0-based).
//  Throughput: 1 pixel/cycle when m_ready stays high; latency from accept to m_valid = 3 cycles.
//  pe_o_valid without an outstanding pe_p_valid: ignored (not pushed).
//  Reset mid-frame clears everything immediately; no partial m_last or done pulse.
// STRUCTURE
//  Shared include pe_pkg.vh: FSM state localparams (IDLE,RUN,DRAIN,DONE, 2-bit),
//   PIX_W=8, RES_W=16, W_W=8.
//  One sub-module: pe_out_fifo (sync FWFT FIFO, DEPTH/WIDTH params, async rstn).
//  Counters: $clog2(IMG_W), $clog2(ROWS), output count $clog2(ROWS*IMG_W).
// TESTING (bench instantiates a real pe behind the scheduler)
//  1 IMG_W=8,ROWS=2, w=(64,0,-64), pixels 10,20,...,80 per row, m_ready=1 ->
//    6 results/row, each -20 (0xFFEC); 12 total; m_last on the 12th; done 1 cycle later.
//  2 w=(1,1,1), pixels all 255, m_ready=0 -> s_pix_ready drops once FIFO+in-flight=4;
//    exactly 4 results are held; release m_ready -> all 12 arrive, each 765>>>6=11, none lost.
//  3 Row boundary: row0 pixels 1..8, row1 pixels 100..107 -> no window mixes 8 with 100;
//    first row1 pe_p = 0x646566.
//  4 start pulsed during RUN with different cfg_w -> ignored; pe_w* unchanged; result count unchanged.
//  5 rstn asserted mid-row 1 -> all outputs 0 next edge; new start runs a clean frame,
//    first result matches case 1.
//  6 Random m_ready and s_pix_valid gaps (1000 cycles) -> output sequence equals the golden model,
//    m_last exactly once.

Source files
------------

// File: rtl/pe_row_sched_pkg.sv
// pe_row_sched_pkg: shared widths, FSM state encoding and helpers for the PE row scheduler.
// Revision: 1.0
`default_nettype none

package pe_row_sched_pkg;

  localparam int PIX_W = 8;
  localparam int RES_W = 16;
  localparam int W_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counter width that stays legal when the range collapses to a single value.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_row_sched_fifo.sv
// pe_row_sched_fifo: synchronous first-word-fall-through result FIFO, async active-low reset.
// Revision: 1.0
`default_nettype none

module pe_row_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign w_pop  = pop_i & (cnt_q != '0);
  assign w_push = push_i & ((cnt_q != C_FULL) | w_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (w_pop) rd_q <= rd_q + 1'b1;
      if (w_push && !w_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!w_push && w_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign pop_data_o = mem_q[rd_q];
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pe_row_sched.sv
// pe_row_sched: feeds a 3-tap PE from a pixel stream with a per-row sliding window and streams its results.
// Revision: 1.0
`default_nettype none

module pe_row_sched
  import pe_row_sched_pkg::*;
#(
  parameter int IMG_W     = 32,
  parameter int ROWS      = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [3*W_W-1:0]     cfg_w,
  output logic                 busy,
  output logic                 done,
  input  logic [PIX_W-1:0]     s_pix_data,
  input  logic                 s_pix_valid,
  output logic                 s_pix_ready,
  output logic [W_W-1:0]       pe_w1,
  output logic [W_W-1:0]       pe_w2,
  output logic [W_W-1:0]       pe_w3,
  output logic [3*PIX_W-1:0]   pe_p,
  output logic                 pe_p_valid,
  input  logic [RES_W-1:0]     pe_o,
  input  logic                 pe_o_valid,
  output logic [RES_W-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = clog2_min1(ROWS);
  localparam int OUT_W = $clog2(ROWS * IMG_W);
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] C_COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [OUT_W-1:0] C_RES_LAST = OUT_W'(ROWS * (IMG_W - 2) - 1);
  localparam logic [OCC_W-1:0] C_OCC_MAX  = OCC_W'(OUT_DEPTH);

  state_t             state_q;
  logic               busy_q;
  logic               done_q;
  logic [3*W_W-1:0]   w_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [3*PIX_W-1:0] win_q, win_d;
  logic               p_valid_q, p_valid_d;
  logic               pend_q;
  logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [CNT_W-1:0]   w_fifo_cnt;
  logic [OCC_W-1:0]   w_occ;

  // Every window in flight already owns a FIFO slot, so a result can never be dropped.
  assign w_occ       = OCC_W'(w_fifo_cnt) + OCC_W'(p_valid_q) + OCC_W'(pend_q);
  assign s_pix_ready = (state_q == S_RUN) && (w_occ < C_OCC_MAX);
  assign w_accept    = s_pix_valid & s_pix_ready;
  assign w_push      = pe_o_valid & pend_q;
  assign w_pop       = m_valid & m_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      w_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            w_q     <= cfg_w;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (col_q == C_COL_LAST) begin
              col_q <= '0;
              row_q <= (row_q == C_ROW_LAST) ? '0 : row_q + 1'b1;
              if (row_q == C_ROW_LAST) state_q <= S_DRAIN;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_empty && !p_valid_q && !pend_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    win_d     = win_q;
    p_valid_d = 1'b0;
    out_cnt_d = out_cnt_q;
    if (w_accept) begin
      win_d     = {win_q[2*PIX_W-1:0], s_pix_data};
      p_valid_d = (col_q >= C_COL_TWO);
    end
    if (state_q == S_IDLE && start) out_cnt_d = '0;
    else if (w_pop)                 out_cnt_d = out_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_q     <= '0;
      p_valid_q <= 1'b0;
      pend_q    <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      win_q     <= win_d;
      p_valid_q <= p_valid_d;
      pend_q    <= p_valid_q;
      out_cnt_q <= out_cnt_d;
    end
  end

  pe_row_sched_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (w_push),
    .push_data_i (pe_o),
    .pop_i       (w_pop),
    .pop_data_o  (m_data),
    .empty_o     (w_empty),
    .count_o     (w_fifo_cnt)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign pe_w1      = w_q[3*W_W-1:2*W_W];
  assign pe_w2      = w_q[2*W_W-1:W_W];
  assign pe_w3      = w_q[W_W-1:0];
  assign pe_p       = win_q;
  assign pe_p_valid = p_valid_q;
  assign m_valid    = !w_empty;
  assign m_last     = m_valid && (out_cnt_q == C_RES_LAST);

endmodule

`default_nettype wire

// File: tb/tb_pe_row_sched.sv
// tb_pe_row_sched: scoreboard bench for pe_row_sched with a behavioural 3-tap PE behind it.
`timescale 1ns/1ps
`default_nettype none

module tb_pe_row_sched;

  localparam int IMG_W = 8;
  localparam int ROWS  = 2;
  localparam int NPIX  = IMG_W * ROWS;
  localparam int NRES  = ROWS * (IMG_W - 2);

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [23:0] cfg_w = '0;
  logic        busy, done;
  logic [7:0]  s_pix_data = '0;
  logic        s_pix_valid = 1'b0;
  logic        s_pix_ready;
  logic [7:0]  pe_w1, pe_w2, pe_w3;
  logic [23:0] pe_p;
  logic        pe_p_valid;
  logic [15:0] pe_o;
  logic        pe_o_valid;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;

  int checks = 0;
  int errors = 0;
  int res_cnt = 0, last_cnt = 0, done_cnt = 0, pv_cnt = 0;
  logic [16:0] exp_q[$];
  logic [23:0] pv_log[$];
  logic [16:0] e;
  logic [7:0]  pix [NPIX];
  logic        rand_mode = 1'b0;
  logic        abort = 1'b0;

  always #5 clk = ~clk;

  pe_row_sched #(.IMG_W(IMG_W), .ROWS(ROWS), .OUT_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_w(cfg_w), .busy(busy), .done(done),
    .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
    .pe_w1(pe_w1), .pe_w2(pe_w2), .pe_w3(pe_w3), .pe_p(pe_p), .pe_p_valid(pe_p_valid),
    .pe_o(pe_o), .pe_o_valid(pe_o_valid), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  // Reference PE: signed weights times unsigned pixels, arithmetic shift by 6.
  function automatic logic [15:0] pe_fn(input logic [23:0] w, input logic [23:0] p);
    int acc;
    acc = int'($signed(w[23:16])) * int'(p[23:16])
        + int'($signed(w[15:8]))  * int'(p[15:8])
        + int'($signed(w[7:0]))   * int'(p[7:0]);
    return 16'(acc >>> 6);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pe_o       <= '0;
      pe_o_valid <= 1'b0;
    end else begin
      pe_o_valid <= pe_p_valid;
      pe_o       <= pe_fn({pe_w1, pe_w2, pe_w3}, pe_p);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rstn && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h with nothing expected at %0t", m_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("m_data", 32'(m_data), 32'(e[15:0]));
        check("m_last", 32'(m_last), 32'(e[16]));
      end
      res_cnt++;
      if (m_last) last_cnt++;
    end
    if (rstn && pe_p_valid) begin
      pv_log.push_back(pe_p);
      pv_cnt++;
    end
    if (rstn && done) done_cnt++;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_begin();
    res_cnt = 0; last_cnt = 0; done_cnt = 0; pv_cnt = 0;
    pv_log.delete();
  endtask

  task automatic expect_const(input logic [15:0] v);
    for (int k = 0; k < NRES; k++) exp_q.push_back({(k == NRES - 1), v});
  endtask

  task automatic expect_model(input logic [23:0] w);
    int k;
    k = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 2; c < IMG_W; c++) begin
        exp_q.push_back({(k == NRES - 1),
                         pe_fn(w, {pix[r*IMG_W+c-2], pix[r*IMG_W+c-1], pix[r*IMG_W+c]})});
        k++;
      end
  endtask

  task automatic do_start(input logic [23:0] w);
    cfg_w = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_w = '0;
  endtask

  task automatic send_pix(input logic [7:0] p);
    logic rdy;
    int   guard;
    rdy = 1'b0;
    guard = 0;
    if (rand_mode) repeat ($urandom_range(0, 2)) tick();
    s_pix_data  = p;
    s_pix_valid = 1'b1;
    while (!rdy && !abort) begin
      @(negedge clk);
      rdy = s_pix_ready;
      tick();
      guard++;
      if (!rdy && guard > 300) begin
        checks++;
        errors++;
        $display("FAIL pixel_timeout: pixel 0x%0h not accepted within 300 cycles", p);
        abort = 1'b1;
      end
    end
    s_pix_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < NPIX; i++) if (!abort) send_pix(pix[i]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("done_pulse_count", 32'(done_cnt), 32'd1);
    check("result_count", 32'(res_cnt), 32'(NRES));
    check("m_last_count", 32'(last_cnt), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},        32'(busy), 32'd0);
    check({tag, "_done"},        32'(done), 32'd0);
    check({tag, "_s_pix_ready"}, 32'(s_pix_ready), 32'd0);
    check({tag, "_pe_p_valid"},  32'(pe_p_valid), 32'd0);
    check({tag, "_m_valid"},     32'(m_valid), 32'd0);
    check({tag, "_m_last"},      32'(m_last), 32'd0);
    check({tag, "_pe_p"},        32'(pe_p), 32'd0);
    check({tag, "_pe_w"},        32'({pe_w1, pe_w2, pe_w3}), 32'd0);
    check({tag, "_m_data"},      32'(m_data), 32'd0);
  endtask

  task automatic fill_ramp(input int base0, input int step0, input int base1, input int step1);
    for (int c = 0; c < IMG_W; c++) begin
      pix[c]         = 8'(base0 + step0 * c);
      pix[IMG_W + c] = 8'(base1 + step1 * c);
    end
  endtask

  initial begin
    int mix;
    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check_all_zero("reset");
    tick();
    rstn = 1'b1;
    tick();

    // 1: 10..80 per row, w=(64,0,-64) -> -20 each
    fill_ramp(10, 10, 10, 10);
    frame_begin();
    expect_const(16'hFFEC);
    do_start(24'h40_00_C0);
    check("busy_after_start", 32'(busy), 32'd1);
    send_frame();
    wait_done();
    check("weights_case1", 32'({pe_w1, pe_w2, pe_w3}), 32'h40_00_C0);

    // 2: backpressure, all 255, w=(1,1,1) -> 11 each, 4 held
    for (int i = 0; i < NPIX; i++) pix[i] = 8'hFF;
    m_ready = 1'b0;
    frame_begin();
    expect_const(16'h000B);
    do_start(24'h01_01_01);
    fork
      send_frame();
      begin
        repeat (30) tick();
        check("stall_ready_low", 32'(s_pix_ready), 32'd0);
        check("stall_windows_issued", 32'(pv_cnt), 32'd4);
        check("stall_m_valid", 32'(m_valid), 32'd1);
        check("stall_head", 32'(m_data), 32'h000B);
        repeat (10) tick();
        check("stall_windows_held", 32'(pv_cnt), 32'd4);
        check("stall_no_output", 32'(res_cnt), 32'd0);
        m_ready = 1'b1;
      end
    join
    wait_done();

    // 3: row boundary, 1..8 then 100..107 -> -2 each
    fill_ramp(1, 1, 100, 1);
    frame_begin();
    expect_const(16'hFFFE);
    do_start(24'h40_00_C0);
    send_frame();
    wait_done();
    check("window_count", 32'(pv_cnt), 32'(NRES));
    if (pv_log.size() > 6) check("first_row1_window", 32'(pv_log[6]), 32'h646566);
    else check("first_row1_window_present", 32'(pv_log.size()), 32'd7);
    mix = 0;
    foreach (pv_log[i]) if ((pv_log[i][23:16] < 8'd100) != (pv_log[i][7:0] < 8'd100)) mix++;
    check("no_row_mix", 32'(mix), 32'd0);

    // 4: start during RUN with other weights is ignored
    fill_ramp(10, 10, 10, 10);
    frame_begin();
    expect_const(16'hFFEC);
    do_start(24'h40_00_C0);
    fork
      send_frame();
      begin
        repeat (6) tick();
        cfg_w = 24'h01_01_01;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_w = '0;
        tick();
        check("weights_held", 32'({pe_w1, pe_w2, pe_w3}), 32'h40_00_C0);
        check("busy_held", 32'(busy), 32'd1);
      end
    join
    wait_done();

    // 5: reset in the middle of row 1, then a clean frame
    frame_begin();
    expect_const(16'hFFEC);
    do_start(24'h40_00_C0);
    for (int i = 0; i < IMG_W + 2; i++) send_pix(pix[i]);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    check("midreset_no_last", 32'(last_cnt), 32'd0);
    check("midreset_no_done", 32'(done_cnt), 32'd0);
    frame_begin();
    expect_const(16'hFFEC);
    do_start(24'h40_00_C0);
    send_frame();
    wait_done();

    // 6: random gaps and m_ready against the reference model
    rand_mode = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom_range(0, 255));
      frame_begin();
      expect_model(24'h03_FB_07);
      do_start(24'h03_FB_07);
      send_frame();
      wait_done();
    end
    rand_mode = 1'b0;
    m_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
